// File: rtl/irq_dispatch.sv
// Interrupt transmitter: edge-detects 16 request lines into a pending register, arbitrates,
// delivers one interrupt at a time to the frontend, then waits for EOI and a hold-off gap.
module irq_dispatch #(
  parameter int HOLDOFF     = 8,
  parameter int PRIO_ROTATE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irq_req,
  input  logic [15:0] irq_mask,
  input  logic        irq_eoi,
  input  logic [3:0]  irq_eoi_num,
  output logic        irqload,
  output logic [3:0]  irqnum,
  output logic        irq_busy,
  output logic [15:0] irq_pending,
  output logic        eoi_err
);

  localparam int CW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int HOLD_INIT = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_EOI, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [15:0]     req_prev_reg;
  logic [15:0]     pending_reg, pending_next;
  logic [15:0]     req_rise, eligible, grant_clr;
  logic [3:0]      irqnum_reg, irqnum_next;
  logic            irqload_reg, irqload_next;
  logic            eoi_err_reg, eoi_err_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      arb_start, arb_idx, winner;
  logic            win_valid;

  assign req_rise = irq_req & ~req_prev_reg;
  assign eligible = pending_reg & ~irq_mask;

  // A new rising edge wins over a same-cycle dispatch clear on the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pending
      assign pending_next[gi] = req_rise[gi] | (pending_reg[gi] & ~grant_clr[gi]);
    end
  endgenerate

  // Scan from highest offset down so the lowest offset from arb_start is kept.
  always_comb begin
    arb_start = (PRIO_ROTATE != 0) ? irqnum_reg + 4'd1 : 4'd0;
    arb_idx   = arb_start;
    winner    = 4'd0;
    win_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      arb_idx = arb_start + 4'(i);
      if (eligible[arb_idx]) begin
        winner    = arb_idx;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    irqnum_next  = irqnum_reg;
    irqload_next = 1'b0;
    eoi_err_next = 1'b0;
    cnt_next     = cnt_reg;
    grant_clr    = 16'd0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next   = SEND;
          irqnum_next  = winner;
          irqload_next = 1'b1;
          grant_clr    = 16'd1 << winner;
        end
      end
      SEND: state_next = WAIT_EOI;
      WAIT_EOI: begin
        if (irq_eoi) begin
          if (irq_eoi_num == irqnum_reg) begin
            state_next = (HOLDOFF == 0) ? IDLE : HOLD;
            cnt_next   = CW'(HOLD_INIT);
          end else begin
            eoi_err_next = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (irq_eoi && state_reg != WAIT_EOI) eoi_err_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_prev_reg <= 16'd0;
      pending_reg  <= 16'd0;
      irqnum_reg   <= 4'd0;
      irqload_reg  <= 1'b0;
      eoi_err_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      req_prev_reg <= irq_req;
      pending_reg  <= pending_next;
      irqnum_reg   <= irqnum_next;
      irqload_reg  <= irqload_next;
      eoi_err_reg  <= eoi_err_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign irqload     = irqload_reg;
  assign irqnum      = irqnum_reg;
  assign irq_busy    = (state_reg != IDLE);
  assign irq_pending = pending_reg;
  assign eoi_err     = eoi_err_reg;

endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: a fixed-priority instance with HOLDOFF=8 and a
// round-robin instance with HOLDOFF=0; deliveries are checked against queued expectations.
module tb_irq_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fixed-priority instance
  logic        f_rst, f_eoi_s, f_irqload, f_busy, f_eoi_err;
  logic [15:0] f_req, f_mask, f_pending;
  logic [3:0]  f_eoi_num, f_irqnum;
  // round-robin instance
  logic        r_rst, r_eoi_s, r_irqload, r_busy, r_eoi_err;
  logic [15:0] r_req, r_mask, r_pending;
  logic [3:0]  r_eoi_num, r_irqnum;

  int f_q[$];
  int r_q[$];

  irq_dispatch #(.HOLDOFF(8), .PRIO_ROTATE(0)) u_fix (
    .clk(clk), .rst(f_rst), .irq_req(f_req), .irq_mask(f_mask), .irq_eoi(f_eoi_s),
    .irq_eoi_num(f_eoi_num), .irqload(f_irqload), .irqnum(f_irqnum), .irq_busy(f_busy),
    .irq_pending(f_pending), .eoi_err(f_eoi_err)
  );

  irq_dispatch #(.HOLDOFF(0), .PRIO_ROTATE(1)) u_rr (
    .clk(clk), .rst(r_rst), .irq_req(r_req), .irq_mask(r_mask), .irq_eoi(r_eoi_s),
    .irq_eoi_num(r_eoi_num), .irqload(r_irqload), .irqnum(r_irqnum), .irq_busy(r_busy),
    .irq_pending(r_pending), .eoi_err(r_eoi_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic f_eoi(input logic [3:0] n);
    f_eoi_s = 1'b1; f_eoi_num = n;
    step;
    f_eoi_s = 1'b0; f_eoi_num = 4'd0;
  endtask

  task automatic r_eoi(input logic [3:0] n);
    r_eoi_s = 1'b1; r_eoi_num = n;
    step;
    r_eoi_s = 1'b0; r_eoi_num = 4'd0;
  endtask

  task automatic wait_idle_f;
    int n;
    n = 0;
    while (f_busy && n < 40) begin step; n++; end
    if (f_busy) check("fix_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_load_r;
    int n;
    n = 0;
    while (!r_irqload && n < 20) begin step; n++; end
    check("rr_load_seen", 32'(r_irqload), 32'd1);
  endtask

  // Scoreboard: every delivery pops one expected interrupt number.
  always @(negedge clk) begin
    if (f_irqload) begin
      $display("fix deliver irqnum=%0d", f_irqnum);
      if (f_q.size() == 0) check("fix_unexpected_load", 32'd1, 32'd0);
      else check("fix_irqnum", 32'(f_irqnum), 32'(f_q.pop_front()));
    end
    if (r_irqload) begin
      $display("rr  deliver irqnum=%0d", r_irqnum);
      if (r_q.size() == 0) check("rr_unexpected_load", 32'd1, 32'd0);
      else check("rr_irqnum", 32'(r_irqnum), 32'(r_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    f_rst = 1'b1; f_req = '0; f_mask = '0; f_eoi_s = 1'b0; f_eoi_num = '0;
    r_rst = 1'b1; r_req = '0; r_mask = '0; r_eoi_s = 1'b0; r_eoi_num = '0;
    repeat (3) step;
    check("rst_irqload", 32'(f_irqload), 32'd0);
    check("rst_irqnum",  32'(f_irqnum),  32'd0);
    check("rst_busy",    32'(f_busy),    32'd0);
    check("rst_pending", 32'(f_pending), 32'd0);
    check("rst_eoi_err", 32'(f_eoi_err), 32'd0);
    f_rst = 1'b0; r_rst = 1'b0;
    step;

    // single request, level held high afterwards
    f_req = 16'h0020;
    step;
    check("t1_pending_set", 32'(f_pending), 32'h0020);
    check("t1_no_load_yet", 32'(f_irqload), 32'd0);
    f_q.push_back(5);
    step;
    check("t1_load",        32'(f_irqload), 32'd1);
    check("t1_pending_clr", 32'(f_pending), 32'd0);
    check("t1_busy",        32'(f_busy),    32'd1);
    step;
    check("t1_load_one_cycle", 32'(f_irqload), 32'd0);
    f_eoi(4'd5);
    check("t1_eoi_ok_no_err", 32'(f_eoi_err), 32'd0);
    check("t1_hold_busy",     32'(f_busy),    32'd1);
    wait_idle_f;

    // simultaneous 3 and 9, then hold-off gap of HOLDOFF+1 cycles
    f_req = 16'h0228;
    f_q.push_back(3);
    f_q.push_back(9);
    step;
    check("t2_pending", 32'(f_pending), 32'h0208);
    step;
    check("t2_load3",   32'(f_irqload), 32'd1);
    check("t2_num3",    32'(f_irqnum),  32'd3);
    step;
    step;
    f_eoi(4'd3);
    for (int k = 1; k <= 8; k++) begin
      step;
      check("t2_gap_no_load", 32'(f_irqload), 32'd0);
    end
    step;
    check("t2_load9", 32'(f_irqload), 32'd1);
    check("t2_num9",  32'(f_irqnum),  32'd9);
    step;

    // mismatched EOI, matching EOI, then EOI during hold
    f_eoi(4'd4);
    check("t4_err_pulse", 32'(f_eoi_err), 32'd1);
    check("t4_still_busy", 32'(f_busy),   32'd1);
    step;
    check("t4_err_cleared", 32'(f_eoi_err), 32'd0);
    f_eoi(4'd9);
    check("t4_match_no_err", 32'(f_eoi_err), 32'd0);
    f_eoi(4'd9);
    check("t4_err_in_hold", 32'(f_eoi_err), 32'd1);
    check("t4_hold_busy",   32'(f_busy),    32'd1);
    wait_idle_f;

    // masked source stays pending until unmasked
    f_mask = 16'h0080;
    f_req  = f_req | 16'h0080;
    repeat (4) step;
    check("t5_masked_pending", 32'(f_pending), 32'h0080);
    check("t5_masked_idle",    32'(f_busy),    32'd0);
    f_q.push_back(7);
    f_mask = 16'h0000;
    step;
    check("t5_unmask_load", 32'(f_irqload), 32'd1);
    check("t5_unmask_num",  32'(f_irqnum),  32'd7);
    step;
    f_eoi(4'd7);
    wait_idle_f;

    // reset while irqload is high
    f_req = 16'h0000;
    step;
    f_req = 16'h0002;
    step;
    step;
    check("t6_load_before_rst", 32'(f_irqload), 32'd1);
    f_rst = 1'b1;
    #1;
    check("t6_rst_irqload", 32'(f_irqload), 32'd0);
    check("t6_rst_busy",    32'(f_busy),    32'd0);
    check("t6_rst_pending", 32'(f_pending), 32'd0);
    f_req = 16'h0000;
    step;
    step;
    f_rst = 1'b0;
    repeat (3) step;
    check("t6_after_busy",    32'(f_busy),    32'd0);
    check("t6_after_pending", 32'(f_pending), 32'd0);

    // round robin: last sent 14, pending {2,15} -> 15 then 2; then {1,3} -> 3 then 1
    r_req = 16'h4000;
    r_q.push_back(14);
    wait_load_r;
    step;
    r_eoi(4'd14);
    check("rr_idle_after_eoi", 32'(r_busy), 32'd0);
    r_req = 16'h0000;
    step;
    r_req = 16'h8004;
    r_q.push_back(15);
    r_q.push_back(2);
    wait_load_r;
    step;
    r_eoi(4'd15);
    wait_load_r;
    step;
    r_eoi(4'd2);
    r_req = 16'h0000;
    step;
    r_req = 16'h000A;
    r_q.push_back(3);
    r_q.push_back(1);
    wait_load_r;
    step;
    r_eoi(4'd3);
    wait_load_r;
    step;
    r_eoi(4'd1);
    check("rr_eoi_no_err", 32'(r_eoi_err), 32'd0);
    repeat (4) step;

    check("fix_queue_drained", 32'(f_q.size()), 32'd0);
    check("rr_queue_drained",  32'(r_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
